// File: rtl/param_shift_register.sv
// WIDTH-bit shift register with direction/rotate control, parallel load, registered
// serial output and an autonomous counted burst-shift engine (start/busy/done).
module param_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             shift_enable,
    input  logic             dir,
    input  logic             rotate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [CW-1:0]    burst_len,
    output logic [WIDTH-1:0] stored_data,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             serial_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] shift_d;
    logic             out_d;
    logic             in_bit;

    // One shift step of the current word; shared by single-step and burst paths.
    always_comb begin
        out_d   = dir ? data_q[0] : data_q[WIDTH-1];
        in_bit  = rotate ? out_d : data;
        shift_d = dir ? {in_bit, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], in_bit};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= RESET_VALUE;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                // Load overrides everything and silently abandons any burst.
                data_q  <= load_data;
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            cnt_q <= burst_len;
                            if (burst_len != '0) begin
                                state_q <= BURST;
                                busy_q  <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else if (shift_enable) begin
                            data_q   <= shift_d;
                            serial_q <= out_d;
                        end
                    end
                    BURST: begin
                        data_q   <= shift_d;
                        serial_q <= out_d;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign stored_data = data_q;
    assign serial_out  = serial_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Scoreboard bench for param_shift_register: expected burst results are queued by the
// stimulus and popped by a monitor on every done pulse; other behaviour is checked inline.
module tb_param_shift_register;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             data;
    logic             shift_enable;
    logic             dir;
    logic             rotate;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [CW-1:0]    burst_len;
    logic [WIDTH-1:0] stored_data;
    logic             serial_out;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             sout;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    param_shift_register #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .shift_enable (shift_enable),
        .dir          (dir),
        .rotate       (rotate),
        .load         (load),
        .load_data    (load_data),
        .start        (start),
        .burst_len    (burst_len),
        .stored_data  (stored_data),
        .serial_out   (serial_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the next queued burst result.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending burst at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (stored_data !== e.word || serial_out !== e.sout) begin
                    fails++;
                    $display("FAIL done_result: got word=%0h sout=%0b expected word=%0h sout=%0b",
                             stored_data, serial_out, e.word, e.sout);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1;
        load_data = v;
        step();
        load = 1'b0;
    endtask

    // Issue start, then count cycles with busy high (bounded); optionally poke
    // shift_enable/start during the burst at a given busy cycle.
    task automatic run_burst(input logic [CW-1:0] len, input int poke_at, output int nbusy);
        start = 1'b1;
        burst_len = len;
        step();
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            nbusy++;
            if (nbusy == poke_at) begin
                shift_enable = 1'b1;
                start = 1'b1;
            end else begin
                shift_enable = 1'b0;
                start = 1'b0;
            end
            step();
        end
        shift_enable = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        reset = 1'b0; data = 1'b0; shift_enable = 1'b0; dir = 1'b0; rotate = 1'b0;
        load = 1'b0; load_data = '0; start = 1'b0; burst_len = '0;
        #12;
        chk("reset_word", 32'(stored_data), 32'h00);
        chk("reset_flags", {29'd0, serial_out, busy, done}, 32'h0);
        step();
        reset = 1'b1;
        step();

        // Single steps, shift left inserting data
        data = 1'b1; shift_enable = 1'b1;
        step();
        shift_enable = 1'b0; data = 1'b0;
        chk("step1", 32'(stored_data), 32'h01);
        shift_enable = 1'b1;
        step();
        step();
        shift_enable = 1'b0;
        chk("step3", 32'(stored_data), 32'h04);

        // Rotate-right burst of 3 from 0xA5
        do_load(8'hA5);
        dir = 1'b1; rotate = 1'b1;
        exp_q.push_back('{word: 8'hB4, sout: 1'b1});
        run_burst(4'd3, 0, nb);
        chk("rotr_busy_cycles", 32'(nb), 32'd3);
        chk("rotr_word", 32'(stored_data), 32'hB4);
        chk("rotr_done", 32'(done), 32'd1);
        step();
        chk("rotr_done_pulse", 32'(done), 32'd0);

        // Left non-rotate burst of 8 with ignored start/shift_enable mid-burst
        do_load(8'h81);
        dir = 1'b0; rotate = 1'b0; data = 1'b0;
        exp_q.push_back('{word: 8'h00, sout: 1'b1});
        run_burst(4'd8, 3, nb);
        chk("left_busy_cycles", 32'(nb), 32'd8);
        chk("left_word", 32'(stored_data), 32'h00);
        chk("left_sout", 32'(serial_out), 32'd1);
        step();
        chk("left_no_restart", 32'(busy), 32'd0);

        // Zero-length burst
        do_load(8'h5A);
        exp_q.push_back('{word: 8'h5A, sout: 1'b1});
        start = 1'b1; burst_len = '0;
        step();
        start = 1'b0;
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_word", 32'(stored_data), 32'h5A);
        step();
        chk("zero_done_pulse", 32'(done), 32'd0);

        // Load aborts a burst of 5 on its 2nd busy cycle
        start = 1'b1; burst_len = 4'd5;
        step();
        start = 1'b0;
        step();
        chk("abort_busy_before", 32'(busy), 32'd1);
        do_load(8'h3C);
        chk("abort_word", 32'(stored_data), 32'h3C);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("abort_word_hold", 32'(stored_data), 32'h3C);

        // Asynchronous reset mid-burst, between clock edges
        dir = 1'b1; rotate = 1'b1;
        start = 1'b1; burst_len = 4'd8;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("areset_word", 32'(stored_data), 32'h00);
        chk("areset_flags", {29'd0, serial_out, busy, done}, 32'h0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("areset_idle", {29'd0, serial_out, busy, done}, 32'h0);
        chk("areset_word_hold", 32'(stored_data), 32'h00);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
